// File: rtl/grid_drawer_param.sv
// grid_drawer_param
//
// Purpose:
//   Streams the pixels of a square CELLS x CELLS game grid into the frame-buffer
//   writer. Each clock it emits one pixel as x_out/y_out/colour_out, qualified
//   by plot. All horizontal lines are drawn first, then all vertical lines.
//   A start/busy/done handshake lets the top-level control FSM sequence this
//   drawer with the other drawers.
//
// Configuration macro:
//   GRID_BORDER_EN - when defined, the outer border lines (k = 0 and
//                    k = CELLS) are drawn as well. When undefined, only the
//                    interior lines are drawn, which gives an open
//                    tic-tac-toe style border.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   resetn     in   synchronous, active-low reset
//   start      in   begin a draw; only sampled while idle
//   colour_in  in   line colour, latched when start is accepted
//   busy       out  high while pixels are being plotted
//   done       out  one-cycle pulse after the last pixel
//   x_out      out  pixel x coordinate (X_W bits)
//   y_out      out  pixel y coordinate (Y_W bits)
//   colour_out out  latched line colour
//   plot       out  pixel valid / frame-buffer write enable
module grid_drawer_param #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X0    = 23,
    parameter int Y0    = 3,
    parameter int CELLS = 3,
    parameter int PITCH = 38,
    parameter int THICK = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [2:0]     colour_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           plot
);

    localparam int LEN = CELLS * PITCH + THICK;

`ifdef GRID_BORDER_EN
    localparam int K_LO = 0;
    localparam int K_HI = CELLS;
`else
    localparam int K_LO = 1;
    localparam int K_HI = CELLS - 1;
`endif

    localparam int LINES = K_HI - K_LO + 1;

    localparam logic [31:0] P_LAST    = 32'(LEN - 1);
    localparam logic [31:0] T_LAST    = 32'(THICK - 1);
    localparam logic [31:0] K_FIRST   = 32'(K_LO);
    localparam logic [31:0] K_LAST    = 32'(K_HI);
    localparam logic [31:0] ACC_FIRST = 32'(K_LO * PITCH);
    localparam logic [31:0] PITCH_W   = 32'(PITCH);
    localparam logic [31:0] X0_W      = 32'(X0);
    localparam logic [31:0] Y0_W      = 32'(Y0);

    typedef enum logic [1:0] {
        IDLE,
        HORIZ,
        VERT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] k;
    logic [31:0] t;
    logic [31:0] p;
    logic [31:0] acc;

    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           last_p;
    logic           last_t;
    logic           last_k;

    // The counters always point at the pixel to be emitted on the next edge.
    // acc holds k*PITCH, so the line offset never needs a multiplier. The
    // horizontal pass runs p along x; the vertical pass swaps the roles of
    // the along-line and across-line offsets.
    always_comb begin
        pix_x = X_W'(X0_W + p);
        pix_y = Y_W'(Y0_W + acc + t);
        if (state == VERT) begin
            pix_x = X_W'(X0_W + acc + t);
            pix_y = Y_W'(Y0_W + p);
        end
    end

    assign last_p = (p == P_LAST);
    assign last_t = (t == T_LAST);
    assign last_k = (k == K_LAST);

    // Main sequencer. Every output is registered here, so the pixel for the
    // current counter values appears one edge after the counters hold it.
    // The run ends with one DONE cycle that raises the done pulse and drops
    // plot/busy together. With no lines to draw the run skips straight to
    // DONE, so done still arrives without any plot cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x_out      <= X_W'(X0);
            y_out      <= Y_W'(Y0);
            colour_out <= 3'b111;
            k          <= '0;
            t          <= '0;
            p          <= '0;
            acc        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        colour_out <= colour_in;
                        k          <= K_FIRST;
                        acc        <= ACC_FIRST;
                        t          <= '0;
                        p          <= '0;
                        state      <= (LINES > 0) ? HORIZ : DONE;
                    end
                end

                HORIZ, VERT: begin
                    plot  <= 1'b1;
                    busy  <= 1'b1;
                    x_out <= pix_x;
                    y_out <= pix_y;
                    if (!last_p) begin
                        p <= p + 32'd1;
                    end else begin
                        p <= '0;
                        if (!last_t) begin
                            t <= t + 32'd1;
                        end else begin
                            t <= '0;
                            if (!last_k) begin
                                k   <= k + 32'd1;
                                acc <= acc + PITCH_W;
                            end else begin
                                k     <= K_FIRST;
                                acc   <= ACC_FIRST;
                                state <= (state == HORIZ) ? VERT : DONE;
                            end
                        end
                    end
                end

                DONE: begin
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/grid_drawer_param.md
# grid_drawer_param

Parametrised pixel-stream generator that draws a square N×N game grid into the VGA frame-buffer writer. It emits one pixel per clock as x/y/colour with a plot strobe, and uses a start/busy/done handshake so the top-level control FSM can sequence it with the other drawers. Cell count, cell pitch, line thickness, origin and coordinate widths are parameters. Line colour is latched per run.

## Interface
Parameters:
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- X0, 23: left edge of the grid, in pixels.
- Y0, 3: top edge of the grid, in pixels.
- CELLS, 3: number of cells per side (≥1).
- PITCH, 38: pixel distance between the first rows of consecutive lines (> THICK).
- THICK, 2: line thickness in pixels (≥1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  begin a draw; sampled only in IDLE.
- colour_in  in  3  line colour; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the last plotted pixel.
- done  out  1  one-cycle pulse after the last pixel.
- x_out  out  X_W  pixel x.
- y_out  out  Y_W  pixel y.
- colour_out  out  3  latched colour.
- plot  out  1  pixel valid / write enable.

## Operation
- Definitions:
  - LEN = CELLS·PITCH + THICK, the line length.
  - Line index k covers K_LO..K_HI, where K_LO = 0 and K_HI = CELLS with border, or K_LO = 1 and K_HI = CELLS−1 without border.
  - L = K_HI − K_LO + 1 is the line count.
- States: IDLE, HORIZ, VERT, DONE.
  - IDLE → HORIZ when start = 1 and L > 0.
  - IDLE → DONE when start = 1 and L = 0.
  - HORIZ → VERT after the last horizontal pixel.
  - VERT → DONE after the last vertical pixel.
  - DONE → IDLE unconditionally.
- Pixel order uses nested counters k (outer), t = 0..THICK−1, p = 0..LEN−1 (inner).
  - HORIZ: x = X0 + p, y = Y0 + k·PITCH + t.
  - VERT: x = X0 + k·PITCH + t, y = Y0 + p.
- k·PITCH is held in an accumulator register incremented by PITCH per line. No multiplier.
- Coordinates are computed at full width and truncated to X_W/Y_W. The grid must fit the coordinate space; this is not checked in RTL.
- colour_out holds the latched colour for the whole run and after it, until the next accepted start.
- start while busy or in DONE is ignored.
- Reset values: state IDLE, plot 0, busy 0, done 0, x_out X0, y_out Y0, colour_out 3'b111. All counters 0.
- Reset mid-run aborts immediately. plot drops on the next edge and no done pulse is emitted.

## Timing
- All outputs are registered.
- If start is sampled at edge 0, the first pixel (X0, Y0 + K_LO·PITCH) is valid with plot = 1 after edge 1.
- plot is continuous (one pixel per cycle, no gaps) for N = 2·L·THICK·LEN cycles, covering the horizontal and vertical passes back to back.
- done is high for exactly one cycle, immediately after the last plot cycle. busy = 0 in that cycle.
- The earliest next accepted start is the cycle after done.
- Total latency from start to done is N + 1 cycles. The L = 0 case gives done after edge 1 with no plot.
- busy = plot throughout a run.

## Configuration
- GRID_BORDER_EN:
  - When defined, outer border lines are drawn (k = 0 and k = CELLS), giving L = CELLS + 1.
  - When undefined, only interior lines are drawn, giving L = CELLS − 1. This is the tic-tac-toe style with an open border.
  - The pixel order rules are unchanged in both builds.

## Test plan
- Reset: hold resetn = 0 for 3 cycles → plot = 0, busy = 0, done = 0, x = 23, y = 3, colour_out = 7.
- Defaults with border, start with colour_in = 3'b100 → 1856 contiguous plot cycles.
  - First pixel (23, 3); last horizontal pixel (138, 118); first vertical pixel (23, 3); last pixel (138, 118).
  - colour_out = 4 throughout; done at cycle 1857.
- Defaults without GRID_BORDER_EN → 928 plot cycles. First pixel (23, 41); last pixel (100, 118).
- Pulse start again at plot cycle 100 with colour_in = 3'b010 → ignored; colour_out stays 4 and the total count is unchanged.
- Reset asserted at plot cycle 500 → plot = 0 next cycle, no done pulse; a following start restarts at the first pixel.
- CELLS = 1 without border, start → done after edge 1, plot never asserted.
